// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for a 16-bit LC-3 style datapath.
// Fetches, decodes and steps each instruction, with memory wait timeout.
`timescale 1ns/1ps
module instr_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clka,
  input  logic        reset_in,
  input  logic        run_in,
  input  logic [15:0] instr_in,
  input  logic        mem_rdy_in,
  input  logic        pc_ctl_0_in,
  output logic        mem_en_out,
  output logic        mem_we_out,
  output logic        ld_ir_out,
  output logic        ld_pc_out,
  output logic [1:0]  pc_sel_out,
  output logic        we_reg_out,
  output logic        reg_src_out,
  output logic [1:0]  alu_op_out,
  output logic        br_out,
  output logic [2:0]  nzp_dec_out,
  output logic        err_out,
  output logic [15:0] retire_cnt_out,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_HALT   = 3'b111
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_OFS = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  // Wait counter only needs to reach TIMEOUT-1: the cycle after that
  // would complete the count, so a miss there is the fault.
  localparam int WW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  state_t        w_ret;
  logic [15:0]   r_ir;
  logic [WW-1:0] r_wait;
  logic          r_err;
  logic [15:0]   r_retire_cnt;

  logic [3:0]    w_op;
  logic          w_is_alu;
  logic          w_is_br;
  logic          w_is_jmp;
  logic          w_is_ld;
  logic          w_is_st;
  logic [1:0]    w_alu;

  logic          w_mem_en;
  logic          w_mem_we;
  logic          w_ld_ir;
  logic          w_ld_pc;
  logic [1:0]    w_pc_sel;
  logic          w_we_reg;
  logic          w_reg_src;
  logic [1:0]    w_alu_op;
  logic          w_br;
  logic          w_retire;
  logic          w_in_acc;
  logic          w_wait_inc;
  logic          w_wait_out;
  logic          w_unused_ir;

  assign w_op        = r_ir[15:12];
  assign w_unused_ir = ^r_ir[8:0];

  // Between instructions, run_in decides whether to keep fetching.
  assign w_ret = run_in ? S_FETCH : S_IDLE;

  // Wait accounting is live only while a memory access is outstanding.
  assign w_in_acc   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_wait_out = w_in_acc && !mem_rdy_in && (r_wait == W_LAST);
  assign w_wait_inc = w_in_acc && !mem_rdy_in && !w_wait_out;

  // Opcode classification of the held instruction.
  always_comb begin
    w_is_alu = 1'b0;
    w_is_br  = 1'b0;
    w_is_jmp = 1'b0;
    w_is_ld  = 1'b0;
    w_is_st  = 1'b0;
    w_alu    = ALU_ADD;
    unique case (w_op)
      OP_ADD: begin
        w_is_alu = 1'b1;
        w_alu    = ALU_ADD;
      end
      OP_AND: begin
        w_is_alu = 1'b1;
        w_alu    = ALU_AND;
      end
      OP_NOT: begin
        w_is_alu = 1'b1;
        w_alu    = ALU_NOT;
      end
      OP_BR:   w_is_br  = 1'b1;
      OP_JMP:  w_is_jmp = 1'b1;
      OP_LD:   w_is_ld  = 1'b1;
      OP_ST:   w_is_st  = 1'b1;
      default: ;
    endcase
  end

  // Next-state and strobe decode from the registered state and IR.
  always_comb begin
    w_next    = r_state;
    w_mem_en  = 1'b0;
    w_mem_we  = 1'b0;
    w_ld_ir   = 1'b0;
    w_ld_pc   = 1'b0;
    w_pc_sel  = PC_INC;
    w_we_reg  = 1'b0;
    w_reg_src = 1'b0;
    w_alu_op  = ALU_ADD;
    w_br      = 1'b0;
    w_retire  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (run_in) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_en = 1'b1;
        if (mem_rdy_in) begin
          w_ld_ir  = 1'b1;
          w_ld_pc  = 1'b1;
          w_pc_sel = PC_INC;
          w_next   = S_DECODE;
        end else if (w_wait_out) begin
          w_next = S_HALT;
        end
      end
      S_DECODE: begin
        if (w_is_alu || w_is_br || w_is_jmp)
          w_next = S_EXEC;
        else if (w_is_ld || w_is_st)
          w_next = S_MEM;
        else
          w_next = S_HALT;
      end
      S_EXEC: begin
        if (w_is_alu) begin
          w_we_reg  = 1'b1;
          w_reg_src = 1'b0;
          w_alu_op  = w_alu;
          w_retire  = 1'b1;
          w_next    = w_ret;
        end else if (w_is_br) begin
          w_br   = 1'b1;
          w_next = S_WB;
        end else if (w_is_jmp) begin
          w_ld_pc  = 1'b1;
          w_pc_sel = PC_REG;
          w_retire = 1'b1;
          w_next   = w_ret;
        end else begin
          w_next = S_HALT;
        end
      end
      S_MEM: begin
        w_mem_en = 1'b1;
        w_mem_we = w_is_st;
        if (mem_rdy_in) begin
          if (w_is_st) begin
            w_retire = 1'b1;
            w_next   = w_ret;
          end else begin
            w_next = S_WB;
          end
        end else if (w_wait_out) begin
          w_next = S_HALT;
        end
      end
      S_WB: begin
        if (w_is_br) begin
          if (pc_ctl_0_in) begin
            w_ld_pc  = 1'b1;
            w_pc_sel = PC_OFS;
          end
          w_retire = 1'b1;
          w_next   = w_ret;
        end else if (w_is_ld) begin
          w_we_reg  = 1'b1;
          w_reg_src = 1'b1;
          w_retire  = 1'b1;
          w_next    = w_ret;
        end else begin
          w_next = S_HALT;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
  end

  // State, IR, wait counter, sticky fault and retire count.
  always_ff @(posedge clka or posedge reset_in) begin
    if (reset_in) begin
      r_state      <= S_IDLE;
      r_ir         <= '0;
      r_wait       <= '0;
      r_err        <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_ld_ir)
        r_ir <= instr_in;
      if (w_wait_inc)
        r_wait <= r_wait + WW'(1);
      else
        r_wait <= '0;
      if (w_next == S_HALT)
        r_err <= 1'b1;
      if (w_retire)
        r_retire_cnt <= r_retire_cnt + 16'd1;
    end
  end

  assign mem_en_out     = w_mem_en;
  assign mem_we_out     = w_mem_we;
  assign ld_ir_out      = w_ld_ir;
  assign ld_pc_out      = w_ld_pc;
  assign pc_sel_out     = w_pc_sel;
  assign we_reg_out     = w_we_reg;
  assign reg_src_out    = w_reg_src;
  assign alu_op_out     = w_alu_op;
  assign br_out         = w_br;
  assign nzp_dec_out    = r_ir[11:9];
  assign err_out        = r_err;
  assign retire_cnt_out = r_retire_cnt;
  assign state_out      = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer.
// Expected strobe events are queued by stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_instr_sequencer;

  localparam int TO = 15;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_FETCH = 3'b001;
  localparam logic [2:0] ST_EXEC  = 3'b011;
  localparam logic [2:0] ST_MEM   = 3'b100;
  localparam logic [2:0] ST_WB    = 3'b101;
  localparam logic [2:0] ST_HALT  = 3'b111;

  logic        clka = 1'b0;
  logic        reset_in = 1'b1;
  logic        run_in = 1'b0;
  logic [15:0] instr_in = '0;
  logic        mem_rdy_in = 1'b0;
  logic        pc_ctl_0_in = 1'b0;
  logic        mem_en_out;
  logic        mem_we_out;
  logic        ld_ir_out;
  logic        ld_pc_out;
  logic [1:0]  pc_sel_out;
  logic        we_reg_out;
  logic        reg_src_out;
  logic [1:0]  alu_op_out;
  logic        br_out;
  logic [2:0]  nzp_dec_out;
  logic        err_out;
  logic [15:0] retire_cnt_out;
  logic [2:0]  state_out;

  instr_sequencer #(.TIMEOUT(TO)) dut (
    .clka          (clka),
    .reset_in      (reset_in),
    .run_in        (run_in),
    .instr_in      (instr_in),
    .mem_rdy_in    (mem_rdy_in),
    .pc_ctl_0_in   (pc_ctl_0_in),
    .mem_en_out    (mem_en_out),
    .mem_we_out    (mem_we_out),
    .ld_ir_out     (ld_ir_out),
    .ld_pc_out     (ld_pc_out),
    .pc_sel_out    (pc_sel_out),
    .we_reg_out    (we_reg_out),
    .reg_src_out   (reg_src_out),
    .alu_op_out    (alu_op_out),
    .br_out        (br_out),
    .nzp_dec_out   (nzp_dec_out),
    .err_out       (err_out),
    .retire_cnt_out(retire_cnt_out),
    .state_out     (state_out)
  );

  always #5 clka = ~clka;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  int          acc_lat[$];
  logic [15:0] acc_dat[$];
  logic        go = 1'b0;
  int          wcnt = 0;
  logic [15:0] m_ret = '0;
  logic [2:0]  m_nzp = '0;
  int          n_fetch = 0;
  int          n_memen = 0;
  int          n_wb = 0;

  logic [31:0] w_ev;
  logic [33:0] w_all;
  logic [9:0]  w_strb;

  assign w_ev = {state_out, mem_we_out, ld_ir_out, ld_pc_out,
                 pc_sel_out, we_reg_out, reg_src_out, alu_op_out,
                 br_out, nzp_dec_out, retire_cnt_out};
  assign w_all = {mem_en_out, mem_we_out, ld_ir_out, ld_pc_out,
                  pc_sel_out, we_reg_out, reg_src_out, alu_op_out,
                  br_out, nzp_dec_out, err_out, retire_cnt_out,
                  state_out};
  assign w_strb = {mem_en_out, mem_we_out, ld_ir_out, ld_pc_out,
                   we_reg_out, br_out, pc_sel_out, reg_src_out,
                   alu_op_out[0]};

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] ev(
    input logic [2:0] st, input logic mw, input logic ldir,
    input logic ldpc, input logic [1:0] ps, input logic we,
    input logic rs, input logic [1:0] alu, input logic br,
    input logic [2:0] nzp, input logic [15:0] ret);
    return {st, mw, ldir, ldpc, ps, we, rs, alu, br, nzp, ret};
  endfunction

  // Monitor: cycle counters and scoreboard pop on every strobe event.
  always @(negedge clka) begin
    if (!reset_in) begin
      if (state_out == ST_FETCH) n_fetch++;
      if (state_out == ST_MEM && mem_en_out) n_memen++;
      if (state_out == ST_WB) n_wb++;
      if ((mem_en_out && mem_rdy_in) || ld_ir_out || ld_pc_out ||
          we_reg_out || br_out) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got %0h want none", w_ev);
        end else begin
          chk("event", {32'd0, w_ev}, {32'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Memory responder: acks each queued access after its latency.
  always @(posedge clka) begin
    #2;
    if (reset_in) begin
      mem_rdy_in = 1'b0;
      wcnt = 0;
    end else if ((state_out == ST_FETCH || state_out == ST_MEM) &&
                 acc_lat.size() != 0) begin
      if (wcnt >= acc_lat[0]) begin
        mem_rdy_in = 1'b1;
        instr_in = acc_dat[0];
        void'(acc_lat.pop_front());
        void'(acc_dat.pop_front());
        wcnt = 0;
      end else begin
        mem_rdy_in = 1'b0;
        wcnt++;
      end
    end else begin
      mem_rdy_in = 1'b0;
      wcnt = 0;
    end
    run_in = go && (acc_lat.size() != 0);
  end

  task automatic tick();
    @(posedge clka);
    #3;
  endtask

  task automatic flush();
    exp_q.delete();
    acc_lat.delete();
    acc_dat.delete();
  endtask

  task automatic do_reset();
    go = 1'b0;
    tick();
    reset_in = 1'b1;
    tick();
    flush();
    tick();
    reset_in = 1'b0;
    m_ret = '0;
    m_nzp = '0;
  endtask

  // Queue one instruction's accesses and its expected strobe events.
  task automatic add_instr(input logic [15:0] ins, input int flat,
                           input int mlat);
    logic [2:0] n;
    n = ins[11:9];
    acc_lat.push_back(flat);
    acc_dat.push_back(ins);
    exp_q.push_back(ev(ST_FETCH, 0, 1, 1, 2'b00, 0, 0, 2'b00, 0,
                       m_nzp, m_ret));
    m_nzp = n;
    case (ins[15:12])
      4'h1, 4'h5, 4'h9: begin
        exp_q.push_back(ev(ST_EXEC, 0, 0, 0, 2'b00, 1, 0,
                           (ins[15:12] == 4'h1) ? 2'b00 :
                           (ins[15:12] == 4'h5) ? 2'b01 : 2'b10,
                           0, n, m_ret));
        m_ret++;
      end
      4'h0: begin
        exp_q.push_back(ev(ST_EXEC, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1,
                           n, m_ret));
        if (pc_ctl_0_in)
          exp_q.push_back(ev(ST_WB, 0, 0, 1, 2'b01, 0, 0, 2'b00, 0,
                             n, m_ret));
        m_ret++;
      end
      4'hC: begin
        exp_q.push_back(ev(ST_EXEC, 0, 0, 1, 2'b10, 0, 0, 2'b00, 0,
                           n, m_ret));
        m_ret++;
      end
      4'h2: begin
        acc_lat.push_back(mlat);
        acc_dat.push_back(16'hBEEF);
        exp_q.push_back(ev(ST_MEM, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0,
                           n, m_ret));
        exp_q.push_back(ev(ST_WB, 0, 0, 0, 2'b00, 1, 1, 2'b00, 0,
                           n, m_ret));
        m_ret++;
      end
      4'h3: begin
        acc_lat.push_back(mlat);
        acc_dat.push_back(16'h0000);
        exp_q.push_back(ev(ST_MEM, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0,
                           n, m_ret));
        m_ret++;
      end
      default: ;
    endcase
  endtask

  task automatic run_prog(input string nm);
    logic ok;
    ok = 1'b0;
    go = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (state_out == ST_IDLE && acc_lat.size() == 0 &&
          exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    go = 1'b0;
    chk({nm, "_done"}, {63'd0, ok}, 64'd1);
    if (!ok) do_reset();
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s,
                            input int lim);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (state_out == s) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, {63'd0, ok}, 64'd1);
  endtask

  int snap;

  initial begin
    #2;
    chk("reset_outs", {30'd0, w_all}, 64'd0);
    tick();
    tick();
    reset_in = 1'b0;

    add_instr(16'h1042, 1, 0);
    add_instr(16'h5E3F, 0, 0);
    add_instr(16'h9A7F, 2, 0);
    add_instr(16'hC1C0, 0, 0);
    run_prog("alu_jmp");
    chk("ret_p1", {48'd0, retire_cnt_out}, 64'd4);

    pc_ctl_0_in = 1'b1;
    add_instr(16'h0A05, 0, 0);
    run_prog("br_taken");
    chk("nzp_hold", {61'd0, nzp_dec_out}, 64'd5);

    pc_ctl_0_in = 1'b0;
    snap = n_wb;
    add_instr(16'h0A05, 0, 0);
    run_prog("br_not_taken");
    chk("br_wb_cycles", 64'(n_wb - snap), 64'd1);

    snap = n_memen;
    add_instr(16'h2C10, 0, 3);
    run_prog("ld_delay3");
    chk("ld_memen_cycles", 64'(n_memen - snap), 64'd4);

    snap = n_wb;
    add_instr(16'h3610, 0, 1);
    run_prog("st");
    chk("st_no_wb", 64'(n_wb - snap), 64'd0);

    add_instr(16'h1042, TO - 1, 0);
    run_prog("rdy_at_timeout");
    chk("no_err_at_timeout", {63'd0, err_out}, 64'd0);
    chk("ret_p6", {48'd0, retire_cnt_out}, 64'd9);

    add_instr(16'h2C10, 0, 99);
    go = 1'b1;
    wait_state("reach_mem", ST_MEM, 20);
    tick();
    reset_in = 1'b1;
    #1;
    chk("reset_mid_mem", {30'd0, w_all}, 64'd0);
    go = 1'b0;
    flush();
    tick();
    reset_in = 1'b0;
    m_ret = '0;
    m_nzp = '0;

    snap = n_fetch;
    acc_lat.push_back(99);
    acc_dat.push_back(16'h1042);
    go = 1'b1;
    wait_state("fetch_timeout_halt", ST_HALT, 60);
    chk("timeout_cycles", 64'(n_fetch - snap), 64'(TO));
    chk("timeout_err", {63'd0, err_out}, 64'd1);
    tick();
    tick();
    tick();
    chk("halt_quiet", {51'd0, state_out, w_strb}, {51'd0, ST_HALT, 10'd0});
    do_reset();
    chk("err_cleared", {63'd0, err_out}, 64'd0);

    add_instr(16'hD000, 0, 0);
    go = 1'b1;
    wait_state("illegal_halt", ST_HALT, 20);
    chk("illegal_err", {63'd0, err_out}, 64'd1);
    chk("illegal_events", 64'(exp_q.size()), 64'd0);
    do_reset();

    force dut.r_retire_cnt = 16'hFFFE;
    tick();
    release dut.r_retire_cnt;
    tick();
    chk("preload", {48'd0, retire_cnt_out}, 64'hFFFE);
    m_ret = 16'hFFFE;
    add_instr(16'h1042, 0, 0);
    add_instr(16'h1042, 0, 0);
    run_prog("wrap");
    chk("wrap_zero", {48'd0, retire_cnt_out}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
